timer_multi: RTL and testbench
==============================

// Module: timer_multi
// PURPOSE
//  Parametrised successor to the DMG timer: one shared free-running system counter (DIV source)
//  feeding NUM_CH independent TIMA/TMA/TAC channels, each with its own IRQ. Adds hardware-accurate
//  falling-edge tick detection (DIV-reset and TAC-write glitch ticks) and a delayed overflow reload
//  with a CPU cancel window. Sits on the CPU I/O bus beside the interrupt controller.
// PARAMETERS
//  NUM_CH        2   number of timer channels (1..4)
//  SYSCNT_W      16  system counter width; DIV = sysctr[SYSCNT_W-1 -: 8]
//  RELOAD_DELAY  4   ce ticks between TIMA overflow and TMA reload/IRQ (>=1)
// PORTS
//  clk_sys    in   1        system clock
//  reset_n    in   1        asynchronous, active-low reset
//  ce         in   1        4 MHz CPU clock enable
//  cpu_sel    in   1        register select
//  cpu_addr   in   AW       AW=$clog2(NUM_CH)+2; {ch, reg}: reg 0 DIV, 1 TIMA, 2 TMA, 3 TAC
//  cpu_wr     in   1        write strobe (one clk_sys cycle, qualified by ce)
//  cpu_di     in   8        write data
//  cpu_do     out  8        read data, combinational from cpu_addr
//  irq        out  NUM_CH   per-channel overflow interrupt, one-ce-tick pulse
// BEHAVIOUR
//  - Reset (async): sysctr=0, all TIMA/TMA/TAC=0, reload state IDLE, irq=0.
//  - sysctr += 1 on every ce (wraps). Write to reg 0 of any channel: sysctr <= 0 that tick.
//  - Per channel: sel bit from TAC[1:0]: 00->bit9, 01->bit3, 10->bit5, 11->bit7.
//    e = TAC[2] & sysctr[sel]; e_q registered on ce. Tick when e_q=1 and e=0 (falling edge).
//    Consequences required: DIV write with sel bit 1 ticks; TAC write clearing enable or
//    changing sel from a 1-bit to a 0-bit ticks.
//  - Tick: TIMA += 1 (8-bit). 0xFF+1 -> TIMA=0x00, state PENDING, cnt=RELOAD_DELAY-1.
//  - FSM per channel (advances on ce only):
//    IDLE    -> PENDING on overflow.
//    PENDING -> cnt-- each ce; at cnt=0 -> RELOAD. CPU TIMA write -> IDLE, no reload, no irq.
//    RELOAD  -> TIMA<=TMA, irq=1 for this ce tick, -> IDLE. CPU TIMA write this tick ignored;
//               CPU TMA write this tick: new TMA value is loaded into TIMA.
//  - Tick in PENDING is ignored (TIMA held 0x00); tick in RELOAD is applied after reload.
//  - Tick and CPU TIMA write same ce (IDLE): write wins, no increment.
//  - irq deasserts next ce; irq held 0 while ce=0 only after its pulse tick ends.
//  - Reads: DIV = sysctr top 8 bits; TAC reads {5'b11111, TAC}; all regs readable any time.
//  - Writes without ce are ignored; reset_n low mid-PENDING aborts reload, no irq.
// STRUCTURE
//  - timer_pkg: TAC bit-select constants, register-index enum (REG_DIV..REG_TAC),
//    channel FSM state enum (ST_IDLE, ST_PENDING, ST_RELOAD).
//  - Sub-module timer_channel: TIMA/TMA/TAC, edge detector, reload FSM, irq; instantiated
//    NUM_CH times in a generate loop. Top holds sysctr, address decode, read mux.
// TESTING
//  - TAC=0x05, TIMA=0xFE, TMA=0x80: after 16 ce TIMA=0xFF, after 32 ce TIMA=0x00, irq pulses
//    exactly RELOAD_DELAY ce later with TIMA=0x80.
//  - Overflow then write TIMA=0x33 during PENDING -> no irq, TIMA=0x33 persists.
//  - TMA write 0x44 on RELOAD tick -> TIMA=0x44; TIMA write on RELOAD tick ignored.
//  - TAC=0x05 with sysctr[3]=1, write DIV -> TIMA +1 immediately; write TAC=0x01 likewise +1.
//  - Ch0 TAC=0x04, ch1 TAC=0x07: after 1024 ce ch0 TIMA=1, ch1 TIMA=4; irqs independent.
//  - Assert reset_n low mid-PENDING -> all regs 0, irq never asserts; DIV reads 0x00.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and enums for the multi-channel DMG-style timer
package timer_pkg;
    localparam int TAC_BIT_00 = 9;
    localparam int TAC_BIT_01 = 3;
    localparam int TAC_BIT_10 = 5;
    localparam int TAC_BIT_11 = 7;
    typedef enum logic [1:0] {REG_DIV, REG_TIMA, REG_TMA, REG_TAC} reg_e;
    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_RELOAD} ch_state_e;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one TIMA/TMA/TAC channel with falling-edge tick and delayed overflow reload
module timer_channel
    import timer_pkg::*;
#(
    parameter int SYSCNT_W     = 16,
    parameter int RELOAD_DELAY = 4
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ce,
    input  logic [SYSCNT_W-1:0] sysctr_nx,
    input  logic                wr_tima,
    input  logic                wr_tma,
    input  logic                wr_tac,
    input  logic [7:0]          di,
    output logic [7:0]          tima,
    output logic [7:0]          tma,
    output logic [2:0]          tac,
    output logic                irq
);
    localparam int CW = RELOAD_DELAY > 1 ? $clog2(RELOAD_DELAY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RELOAD_DELAY - 1);
    ch_state_e state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0] tima_nx, tma_nx, base;
    logic [2:0] tac_nx;
    logic e_q, e_nx, sel_bit, tick, irq_nx;

    // edge is taken on post-write values so DIV and TAC writes produce their glitch tick at once
    always_comb begin
        tma_nx = wr_tma ? di : tma;
        tac_nx = wr_tac ? di[2:0] : tac;
        sel_bit = tac_nx[1] ? (tac_nx[0] ? sysctr_nx[TAC_BIT_11] : sysctr_nx[TAC_BIT_10])
                            : (tac_nx[0] ? sysctr_nx[TAC_BIT_01] : sysctr_nx[TAC_BIT_00]);
        e_nx = tac_nx[2] & sel_bit;
        tick = e_q & ~e_nx;
        base = state == ST_RELOAD ? tma_nx : tima;
        state_nx = ST_IDLE;
        cnt_nx = cnt;
        tima_nx = tima;
        irq_nx = 1'b0;
        if (state == ST_PENDING) begin
            if (wr_tima) tima_nx = di;
            else if (cnt == '0) begin
                tima_nx = tma_nx;
                state_nx = ST_RELOAD;
                irq_nx = 1'b1;
            end else begin
                cnt_nx = cnt - CW'(1);
                state_nx = ST_PENDING;
            end
        end else if (wr_tima && state == ST_IDLE) tima_nx = di;
        else if (tick && base == 8'hFF) begin
            tima_nx = 8'h00;
            state_nx = ST_PENDING;
            cnt_nx = CNT_INIT;
        end else tima_nx = base + {7'd0, tick};
    end

    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt <= '0;
            tima <= '0;
            tma <= '0;
            tac <= '0;
            e_q <= 1'b0;
            irq <= 1'b0;
        end else if (ce) begin
            state <= state_nx;
            cnt <= cnt_nx;
            tima <= tima_nx;
            tma <= tma_nx;
            tac <= tac_nx;
            e_q <= e_nx;
            irq <= irq_nx;
        end
endmodule

// File: rtl/timer_multi.sv
// timer_multi: shared system counter (DIV) feeding NUM_CH independent timer channels
module timer_multi
    import timer_pkg::*;
#(
    parameter  int NUM_CH       = 2,
    parameter  int SYSCNT_W     = 16,
    parameter  int RELOAD_DELAY = 4,
    localparam int AW           = $clog2(NUM_CH) + 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              cpu_sel,
    input  logic [AW-1:0]     cpu_addr,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    output logic [NUM_CH-1:0] irq
);
    localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic [SYSCNT_W-1:0] sysctr, sysctr_nx;
    logic [CHW-1:0] ch;
    reg_e reg_idx;
    logic wr, ch_ok;
    logic [7:0] tima [NUM_CH];
    logic [7:0] tma [NUM_CH];
    logic [2:0] tac [NUM_CH];

    assign reg_idx = reg_e'(cpu_addr[1:0]);
    assign wr = cpu_sel & cpu_wr & ce;
    assign sysctr_nx = wr && reg_idx == REG_DIV ? '0 : sysctr + SYSCNT_W'(1);
    assign ch_ok = 32'(ch) < 32'(NUM_CH);

    if (NUM_CH > 1) begin : g_ch
        assign ch = cpu_addr[AW-1:2];
    end else begin : g_one
        assign ch = '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) sysctr <= '0;
        else if (ce) sysctr <= sysctr_nx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        timer_channel #(.SYSCNT_W(SYSCNT_W), .RELOAD_DELAY(RELOAD_DELAY)) u_ch (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .ce       (ce),
            .sysctr_nx(sysctr_nx),
            .wr_tima  (wr && ch == CHW'(i) && reg_idx == REG_TIMA),
            .wr_tma   (wr && ch == CHW'(i) && reg_idx == REG_TMA),
            .wr_tac   (wr && ch == CHW'(i) && reg_idx == REG_TAC),
            .di       (cpu_di),
            .tima     (tima[i]),
            .tma      (tma[i]),
            .tac      (tac[i]),
            .irq      (irq[i])
        );
    end

    always_comb begin
        cpu_do = 8'h00;
        if (reg_idx == REG_DIV) cpu_do = sysctr[SYSCNT_W-1 -: 8];
        else if (ch_ok) cpu_do = reg_idx == REG_TIMA ? tima[ch] :
                                 reg_idx == REG_TMA  ? tma[ch]  : {5'b11111, tac[ch]};
    end
endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: directed stimulus checked against a tick-level behavioural model
module tb_timer_multi;
    localparam int NCH = 2;
    localparam int D = 4;
    localparam int DIV0 = 0, TIMA0 = 1, TMA0 = 2, TAC0 = 3, TIMA1 = 5, TMA1 = 6, TAC1 = 7;

    logic clk_sys = 0;
    logic reset_n = 0;
    logic ce = 0, cpu_sel = 0, cpu_wr = 0;
    logic [2:0] cpu_addr = '0;
    logic [7:0] cpu_di = '0;
    logic [7:0] cpu_do;
    logic [NCH-1:0] irq;
    int checks = 0, failures = 0;

    int SELB [4] = '{9, 3, 5, 7};
    int m_sys;
    int m_tima [NCH], m_tma [NCH], m_tac [NCH], m_age [NCH];
    bit m_e [NCH];

    timer_multi #(.NUM_CH(NCH), .SYSCNT_W(16), .RELOAD_DELAY(D)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .cpu_sel(cpu_sel),
        .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_di(cpu_di), .cpu_do(cpu_do), .irq(irq)
    );

    always #5 clk_sys = ~clk_sys;

    // m_age counts ce ticks since overflow: -1 none, 0..D-1 waiting, D = reload/irq tick
    task automatic m_reset();
        m_sys = 0;
        for (int c = 0; c < NCH; c++) begin
            m_tima[c] = 0; m_tma[c] = 0; m_tac[c] = 0; m_age[c] = -1; m_e[c] = 0;
        end
    endtask

    task automatic m_step(input bit w, input logic [2:0] a, input logic [7:0] d);
        int r, ch, ns;
        r = int'(a) & 3;
        ch = int'(a) >> 2;
        ns = (w && r == 0) ? 0 : (m_sys + 1) % 65536;
        for (int c = 0; c < NCH; c++) begin
            bit wt, e, tick;
            int v;
            wt = w && ch == c && r == 1;
            if (w && ch == c && r == 2) m_tma[c] = int'(d);
            if (w && ch == c && r == 3) m_tac[c] = int'(d) & 7;
            e = (m_tac[c] & 4) != 0 && ((ns >> SELB[m_tac[c] & 3]) & 1) != 0;
            tick = m_e[c] && !e;
            m_e[c] = e;
            if (m_age[c] >= 0 && m_age[c] < D) begin
                if (wt) begin
                    m_tima[c] = int'(d);
                    m_age[c] = -1;
                end else begin
                    m_age[c]++;
                    if (m_age[c] == D) m_tima[c] = m_tma[c];
                end
            end else begin
                v = (m_age[c] == D) ? m_tma[c] : m_tima[c];
                if (wt && m_age[c] != D) v = int'(d);
                else if (tick) v++;
                m_age[c] = -1;
                if (v == 256) begin
                    v = 0;
                    m_age[c] = 0;
                end
                m_tima[c] = v;
            end
        end
        m_sys = ns;
    endtask

    function automatic logic [7:0] m_rd(input logic [2:0] a);
        int c;
        c = int'(a) >> 2;
        case (int'(a) & 3)
            0: return 8'((m_sys >> 8) & 255);
            1: return 8'(m_tima[c]);
            2: return 8'(m_tma[c]);
            default: return 8'(248 | m_tac[c]);
        endcase
    endfunction

    function automatic logic [7:0] m_irq();
        logic [7:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[c] = (m_age[c] == D);
        return r;
    endfunction

    always @(posedge clk_sys or negedge reset_n)
        if (!reset_n) m_reset();
        else if (ce) m_step(cpu_sel && cpu_wr, cpu_addr, cpu_di);

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %02h expected %02h", n, $time, act, exp);
        end
    endtask

    always @(posedge clk_sys) begin
        #2;
        chk("irq_vs_model", {6'd0, irq}, m_irq());
        chk("rd_vs_model", cpu_do, m_rd(cpu_addr));
    end

    task automatic cyc(input logic c, input logic w, input int a, input logic [7:0] d);
        @(negedge clk_sys);
        ce = c; cpu_sel = w; cpu_wr = w; cpu_addr = 3'(a); cpu_di = d;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        cyc(1'b1, 1'b1, a, d);
        cyc(1'b0, 1'b0, a, 8'h00);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, int'(cpu_addr), 8'h00);
            cyc(1'b0, 1'b0, int'(cpu_addr), 8'h00);
        end
    endtask

    task automatic rd_lit(input string n, input int a, input logic [7:0] exp);
        cyc(1'b0, 1'b0, a, 8'h00);
        #1;
        chk(n, cpu_do, exp);
        chk({n, "_model"}, m_rd(3'(a)), exp);
    endtask

    task automatic irq_lit(input string n, input logic [1:0] exp);
        #1;
        chk(n, {6'd0, irq}, {6'd0, exp});
        chk({n, "_model"}, m_irq(), {6'd0, exp});
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        rd_lit("rst_div", DIV0, 8'h00);
        rd_lit("rst_tima0", TIMA0, 8'h00);
        rd_lit("rst_tac1", TAC1, 8'hF8);
        irq_lit("rst_irq", 2'b00);
        @(negedge clk_sys) reset_n = 1;
        // basic count, overflow, delayed reload
        wr(TAC0, 8'h05); wr(TMA0, 8'h80); wr(TIMA0, 8'hFE); wr(DIV0, 8'h00);
        step(16); rd_lit("cnt16", TIMA0, 8'hFF);
        step(16); rd_lit("cnt32_ovf", TIMA0, 8'h00); irq_lit("pend_irq0", 2'b00);
        step(3); irq_lit("pend3_irq", 2'b00);
        step(1); irq_lit("reload_irq", 2'b01); rd_lit("reload_tima", TIMA0, 8'h80);
        step(1); irq_lit("irq_drop", 2'b00);
        // TIMA write during PENDING cancels reload
        wr(TIMA0, 8'hFF); step(10); rd_lit("ovf2", TIMA0, 8'h00);
        step(1); wr(TIMA0, 8'h33); step(8);
        rd_lit("cancel_tima", TIMA0, 8'h33); irq_lit("cancel_irq", 2'b00);
        // writes during the reload tick
        wr(TIMA0, 8'hFF); step(5); step(4); irq_lit("reload2_irq", 2'b01);
        wr(TMA0, 8'h44);
        rd_lit("tma_win_tima", TIMA0, 8'h44); rd_lit("tma_win_tma", TMA0, 8'h44);
        wr(TIMA0, 8'hFF); step(10); step(4); wr(TIMA0, 8'h99);
        rd_lit("tima_win_ignored", TIMA0, 8'h44);
        // glitch ticks from DIV and TAC writes
        step(3); wr(DIV0, 8'h00);
        rd_lit("div_glitch", TIMA0, 8'h45); rd_lit("div_zero", DIV0, 8'h00);
        step(8); wr(TAC0, 8'h01);
        rd_lit("tac_dis_glitch", TIMA0, 8'h46); rd_lit("tac_read", TAC0, 8'hF9);
        wr(TAC0, 8'h05); wr(TAC0, 8'h06);
        rd_lit("tac_sel_glitch", TIMA0, 8'h47);
        cyc(1'b0, 1'b1, TIMA0, 8'h55); cyc(1'b0, 1'b0, TIMA0, 8'h00);
        rd_lit("wr_no_ce", TIMA0, 8'h47);
        // two independent channels
        wr(TAC0, 8'h04); wr(TIMA0, 8'h00); wr(TAC1, 8'h07); wr(TIMA1, 8'h00); wr(DIV0, 8'h00);
        step(1024);
        rd_lit("ch0_1024", TIMA0, 8'h01); rd_lit("ch1_1024", TIMA1, 8'h04);
        rd_lit("div_1024", DIV0, 8'h04);
        wr(TIMA1, 8'hFF); step(255); step(4);
        irq_lit("ch1_irq_only", 2'b10); rd_lit("ch1_reload", TIMA1, 8'h00);
        rd_lit("ch0_untouched", TIMA0, 8'h01);
        step(1);
        // reset in the middle of a pending reload
        wr(TIMA1, 8'hFF); step(250); step(2);
        @(negedge clk_sys) reset_n = 0;
        rd_lit("mid_rst_div", DIV0, 8'h00); rd_lit("mid_rst_tima1", TIMA1, 8'h00);
        rd_lit("mid_rst_tma0", TMA0, 8'h00); rd_lit("mid_rst_tac1", TAC1, 8'hF8);
        irq_lit("mid_rst_irq", 2'b00);
        @(negedge clk_sys) reset_n = 1;
        step(10);
        irq_lit("post_rst_irq", 2'b00); rd_lit("post_rst_tima1", TIMA1, 8'h00);
        rd_lit("post_rst_div", DIV0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
